// File: rtl/stream_extremum.sv
// Streaming max/min finder: tracks the running extremum of a frame of up to LEN
// samples and presents value, index and sample count on a valid/ready output.
module stream_extremum #(
  parameter int WIDTH = 4,
  parameter int LEN   = 8,
  localparam int IDXW = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               sgn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [IDXW-1:0]    out_idx,
  output logic [IDXW:0]      out_count
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t             state;
  logic [IDXW-1:0]    cnt;
  logic [WIDTH-1:0]   best;
  logic [IDXW-1:0]    best_idx;
  logic               mode_f;
  logic               sgn_f;

  logic               first;
  logic               accept;
  logic               frame_end;
  logic [WIDTH-1:0]   nbest;
  logic [IDXW-1:0]    nidx;

  // Sign-extend (or zero-extend) both operands one bit and compare as signed,
  // so a single comparator serves both orderings.
  function automatic logic is_better(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic             s,
                                     input logic             m);
    logic signed [WIDTH:0] ax;
    logic signed [WIDTH:0] bx;
    ax = s ? $signed({a[WIDTH-1], a}) : $signed({1'b0, a});
    bx = s ? $signed({b[WIDTH-1], b}) : $signed({1'b0, b});
    return m ? (ax < bx) : (ax > bx);
  endfunction

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign first     = (cnt == '0);
  assign frame_end = in_last || (cnt == IDXW'(LEN - 1));

  // Candidate extremum including the beat currently on the input; the first
  // beat of a frame is taken unconditionally, ties keep the earlier sample.
  always_comb begin
    nbest = best;
    nidx  = best_idx;
    if (first) begin
      nbest = in_data;
      nidx  = '0;
    end else if (is_better(in_data, best, sgn_f, mode_f)) begin
      nbest = in_data;
      nidx  = cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      cnt       <= '0;
      best      <= '0;
      best_idx  <= '0;
      mode_f    <= 1'b0;
      sgn_f     <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_count <= '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            best     <= nbest;
            best_idx <= nidx;
            if (first) begin
              mode_f <= mode;
              sgn_f  <= sgn;
            end
            if (frame_end) begin
              out_data  <= nbest;
              out_idx   <= nidx;
              out_count <= {1'b0, cnt} + (IDXW + 1)'(1);
              cnt       <= '0;
              state     <= HOLD;
            end else begin
              cnt <= cnt + IDXW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_extremum.sv
// Scoreboard bench for stream_extremum: directed frames from the test plan plus
// randomized frames, checked against a loop-based reference model.
module tb_stream_extremum;
  localparam int WIDTH = 4;
  localparam int LEN   = 4;
  localparam int IDXW  = 2;

  typedef logic [WIDTH-1:0] q_t[$];
  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [IDXW-1:0]  i;
    logic [IDXW:0]    c;
  } res_t;

  logic clk = 1'b0;
  logic rst, mode, sgn, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [IDXW-1:0]  out_idx;
  logic [IDXW:0]    out_count;

  res_t expq[$];
  int   checks = 0;
  int   fails  = 0;
  int   ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  stream_extremum #(.WIDTH(WIDTH), .LEN(LEN)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sgn(sgn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sval(input logic [WIDTH-1:0] x, input logic s);
    return s ? int'($signed(x)) : int'(x);
  endfunction

  // Reference: first index holding the largest (mode 0) or smallest (mode 1) value.
  function automatic res_t model(input q_t s, input logic m, input logic sg);
    res_t r;
    int bi = 0;
    for (int k = 1; k < s.size(); k++) begin
      if (m ? (sval(s[k], sg) < sval(s[bi], sg)) : (sval(s[k], sg) > sval(s[bi], sg)))
        bi = k;
    end
    r.d = s[bi];
    r.i = bi[IDXW-1:0];
    r.c = (IDXW + 1)'(s.size());
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: a result presented with out_ready high is consumed at the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        res_t e;
        e = expq.pop_front();
        check("out_data", out_data, e.d);
        check("out_idx", out_idx, e.i);
        check("out_count", out_count, e.c);
      end
    end
  end

  // Offer the currently driven beat until it is accepted; returns at posedge+1.
  task automatic beat();
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input q_t s, input logic m, input logic sg,
                            input bit use_last, input bit toggle, input bit bubbles);
    for (int k = 0; k < s.size(); k++) begin
      if (bubbles) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = s[k];
      in_last  = use_last && (k == s.size() - 1);
      if (k == 0) begin
        mode = m;
        sgn  = sg;
      end else if (toggle) begin
        mode = 1'($urandom_range(0, 1));
        sgn  = 1'($urandom_range(0, 1));
      end
      beat();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    expq.push_back(model(s, m, sg));
    check("out_valid_latency", out_valid, 1);
    check("in_ready_in_hold", in_ready, 0);
  endtask

  initial begin
    q_t q;
    res_t hold_exp;
    int t;
    rst = 1'b1; mode = 1'b0; sgn = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_count", out_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    q = {4'h3, 4'h9, 4'h9, 4'h2};
    send_frame(q, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    q = {4'h8, 4'h7, 4'h1, 4'h0};
    send_frame(q, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(q, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    q = {4'h7, 4'hF, 4'h8, 4'h1};
    send_frame(q, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(q, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    q = {4'h5, 4'hC};
    send_frame(q, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    q = {4'h6};
    send_frame(q, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Backpressure: result must hold while the input keeps offering 0xF.
    @(negedge clk);
    ready_mode = 0;
    @(posedge clk); #1;
    q = {4'h1, 4'h2, 4'h3, 4'h4};
    hold_exp = model(q, 1'b0, 1'b0);
    send_frame(q, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_data", out_data, hold_exp.d);
      check("bp_out_idx", out_idx, hold_exp.i);
      check("bp_out_count", out_count, hold_exp.c);
    end
    ready_mode = 1;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (out_valid && t < 20);
    in_valid = 1'b0;
    check("bp_release", out_valid, 0);
    check("bp_in_ready_after", in_ready, 1);

    // Reset in the middle of a frame discards the partial frame.
    in_valid = 1'b1; in_data = 4'h9; in_last = 1'b0;
    beat();
    in_data = 4'hF;
    beat();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_idx", out_idx, 0);
    check("mid_rst_out_count", out_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    q = {4'h4, 4'h1, 4'h2, 4'h3};
    send_frame(q, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized frames with bubbles, mode/sgn noise and random out_ready.
    ready_mode = 2;
    for (int f = 0; f < 60; f++) begin
      int n;
      bit ul;
      n = $urandom_range(1, LEN);
      q.delete();
      for (int k = 0; k < n; k++) q.push_back(WIDTH'($urandom));
      ul = (n < LEN) ? 1'b1 : 1'($urandom_range(0, 1));
      send_frame(q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ul, 1'b1, 1'b1);
    end

    ready_mode = 1;
    t = 0;
    while (expq.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    check("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
